// File: rtl/jet_tag_argmax_if.sv
// Handshake bus for the jet-tag argmax stage: one logit vector in, one
// class decision (index, winning logit, margin to runner-up) out.
interface jet_tag_argmax_if #(
    parameter int WIDTH     = 22,
    parameter int N_CLASSES = 5,
    parameter int IDX_W     = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [N_CLASSES*WIDTH-1:0]   in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             out_class;
    logic signed [WIDTH-1:0]      out_max;
    logic [WIDTH-1:0]             out_margin;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_class, out_max, out_margin
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_class, out_max, out_margin
    );
endinterface

// File: rtl/jet_tag_argmax.sv
// Serial argmax over one logit vector using a single signed comparator.
// Reports the winning class, its logit and the saturated margin to the runner-up.
module jet_tag_argmax #(
    parameter int WIDTH     = 22,
    parameter int NFRAC     = 11,
    parameter int N_CLASSES = 5,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    jet_tag_argmax_if.slave  bus
);
    localparam logic [IDX_W-1:0]        LAST    = IDX_W'(N_CLASSES - 1);
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    if (N_CLASSES < 2 || NFRAC >= WIDTH || (1 << IDX_W) < N_CLASSES) begin : g_param_check
        $error("jet_tag_argmax: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [N_CLASSES*WIDTH-1:0]  vec_q, vec_d;
    logic signed [WIDTH-1:0]     best_q, best_d;
    logic signed [WIDTH-1:0]     second_q, second_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            out_class_q, out_class_d;
    logic signed [WIDTH-1:0]     out_max_q, out_max_d;
    logic [WIDTH-1:0]            out_margin_q, out_margin_d;

    logic signed [WIDTH-1:0]     logit_w [N_CLASSES];
    logic signed [WIDTH-1:0]     x;
    logic signed [WIDTH:0]       diff;
    logic                        in_ready_w;
    logic                        accept;

    for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_unpack
        assign logit_w[gi] = vec_q[gi*WIDTH +: WIDTH];
    end

    assign accept = bus.in_valid && in_ready_w;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            best_q       <= '0;
            second_q     <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            out_class_q  <= '0;
            out_max_q    <= '0;
            out_margin_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            best_q       <= best_d;
            second_q     <= second_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            out_class_q  <= out_class_d;
            out_max_q    <= out_max_d;
            out_margin_q <= out_margin_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: strict '>' against best keeps the lowest index on ties,
    // while '>' against second lets an equal-to-best value become second.
    always_comb begin
        vec_d        = vec_q;
        best_d       = best_q;
        second_d     = second_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        out_class_d  = out_class_q;
        out_max_d    = out_max_q;
        out_margin_d = out_margin_q;
        x            = logit_w[cnt_q];
        diff         = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    vec_d    = bus.in_data;
                    best_d   = bus.in_data[WIDTH-1:0];
                    second_d = MIN_VAL;
                    idx_d    = '0;
                    cnt_d    = IDX_W'(1);
                end
            end
            SCAN: begin
                if (x > best_q) begin
                    second_d = best_q;
                    best_d   = x;
                    idx_d    = cnt_q;
                end else if (x > second_q) begin
                    second_d = x;
                end
                cnt_d = cnt_q + IDX_W'(1);
                // best >= second always, so the wide difference is non-negative;
                // only its upper magnitude needs clamping.
                diff = {best_d[WIDTH-1], best_d} - {second_d[WIDTH-1], second_d};
                if (cnt_q == LAST) begin
                    out_class_d  = idx_d;
                    out_max_d    = best_d;
                    out_margin_d = (diff[WIDTH] || diff[WIDTH-1]) ? MAX_POS : diff[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready_w     = (state_q == IDLE) && !reset;
        bus.in_ready   = in_ready_w;
        bus.out_valid  = (state_q == DONE);
        bus.out_class  = out_class_q;
        bus.out_max    = out_max_q;
        bus.out_margin = out_margin_q;
    end
endmodule

// File: tb/tb_jet_tag_argmax.sv
// Directed bench for jet_tag_argmax: nominal, ties, extremes, backpressure,
// mid-scan reset and back-to-back streaming against hand-computed results.
module tb_jet_tag_argmax;
    localparam int W = 22;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    jet_tag_argmax_if #(.WIDTH(W), .N_CLASSES(5), .IDX_W(3)) bus ();

    jet_tag_argmax #(.WIDTH(W), .NFRAC(11), .N_CLASSES(5), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int a, input int b, input int c, input int d, input int e);
        bus.in_data[0*W +: W] = a[W-1:0];
        bus.in_data[1*W +: W] = b[W-1:0];
        bus.in_data[2*W +: W] = c[W-1:0];
        bus.in_data[3*W +: W] = d[W-1:0];
        bus.in_data[4*W +: W] = e[W-1:0];
    endtask

    // Present a vector and return just after the accept edge.
    task automatic send(input int a, input int b, input int c, input int d, input int e);
        int t;
        set_vec(a, b, c, d, e);
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        check_val("in_ready_wait", longint'(t < 50), 1);
        tick();
        bus.in_valid = 1'b0;
        set_vec(-1, -1, -1, -1, -1);
    endtask

    task automatic wait_out(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check_val({tag, "_latency"}, cyc, 4);
    endtask

    task automatic check_out(input string tag, input int cls, input int mx, input int mar);
        check_val({tag, "_class"},  bus.out_class, cls);
        check_val({tag, "_max"},    longint'($signed(bus.out_max)), mx);
        check_val({tag, "_margin"}, bus.out_margin, mar);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input int a, input int b, input int c,
                           input int d, input int e, input int cls, input int mx, input int mar);
        send(a, b, c, d, e);
        wait_out(tag);
        check_out(tag, cls, mx, mar);
        $display("vec %s: class=%0d max=%0d margin=%0d", tag, bus.out_class,
                 $signed(bus.out_max), bus.out_margin);
        release_out();
    endtask

    int bv[3][5];
    int be[3][3];
    int acc_cyc[3];

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        #1;
        check_val("rst_in_ready", bus.in_ready, 0);
        tick();
        tick();
        check_val("rst_out_valid", bus.out_valid, 0);
        check_out("rst", 0, 0, 0);
        reset = 1'b0;
        tick();
        check_val("idle_in_ready", bus.in_ready, 1);

        run_vec("nominal", -128, -129, -144, 168, 441, 4, 441, 273);
        run_vec("tie_all", 100, 100, 100, 100, 100, 0, 100, 0);
        run_vec("tie_pair", 5, 9, 9, 1, 0, 1, 9, 0);
        run_vec("sat", -2097152, -2097152, 2097151, -2097152, -2097152, 2, 2097151, 2097151);
        run_vec("all_min", -2097152, -2097152, -2097152, -2097152, -2097152, 0, -2097152, 0);

        // Backpressure: hold the result for 10 cycles.
        send(10, -20, 30, 25, -5);
        wait_out("bp");
        for (int i = 0; i < 10; i++) begin
            check_val("bp_valid", bus.out_valid, 1);
            check_val("bp_in_ready", bus.in_ready, 0);
            check_out("bp", 2, 30, 5);
            tick();
        end
        $display("vec bp: class=%0d max=%0d margin=%0d", bus.out_class,
                 $signed(bus.out_max), bus.out_margin);
        release_out();
        check_val("bp_idle_in_ready", bus.in_ready, 1);
        check_val("bp_idle_valid", bus.out_valid, 0);
        check_out("bp_hold", 2, 30, 5);
        run_vec("after_bp", 1, 2, 3, 4, -5, 3, 4, 1);

        // Reset two cycles into SCAN.
        send(7, 8, 900, 1, 2);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_val("mid_rst_valid", bus.out_valid, 0);
        check_val("mid_rst_in_ready", bus.in_ready, 0);
        check_out("mid_rst", 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val("post_rst_valid", bus.out_valid, 0);
            tick();
        end
        $display("vec mid_reset: aborted, outputs class=%0d max=%0d margin=%0d",
                 bus.out_class, $signed(bus.out_max), bus.out_margin);
        run_vec("post_rst", 0, 0, 0, 0, 3, 4, 3, 3);

        // Back-to-back with in_valid and out_ready held high.
        bv[0] = '{1, 2, 3, 4, 5};        be[0] = '{4, 5, 1};
        bv[1] = '{-10, 50, -3, 20, 0};   be[1] = '{1, 50, 30};
        bv[2] = '{7, -7, 300, -300, 299}; be[2] = '{2, 300, 1};
        begin
            int k, r, cyc;
            bit adv;
            k = 0;
            r = 0;
            cyc = 0;
            bus.out_ready = 1'b1;
            set_vec(bv[0][0], bv[0][1], bv[0][2], bv[0][3], bv[0][4]);
            bus.in_valid = 1'b1;
            while (r < 3 && cyc < 100) begin
                adv = 1'b0;
                if (bus.in_ready && k < 3) begin
                    acc_cyc[k] = cyc;
                    adv = 1'b1;
                end
                if (bus.out_valid) begin
                    check_out("b2b", be[r][0], be[r][1], be[r][2]);
                    $display("vec b2b%0d: class=%0d max=%0d margin=%0d", r, bus.out_class,
                             $signed(bus.out_max), bus.out_margin);
                    r++;
                end
                tick();
                cyc++;
                if (adv) begin
                    k++;
                    if (k < 3) set_vec(bv[k][0], bv[k][1], bv[k][2], bv[k][3], bv[k][4]);
                    else bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            check_val("b2b_results", r, 3);
            check_val("b2b_gap01", acc_cyc[1] - acc_cyc[0], 6);
            check_val("b2b_gap12", acc_cyc[2] - acc_cyc[1], 6);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/jet_tag_argmax.md
# jet_tag_argmax

Output-decision stage of the Batchnorm-JetTagging network, directly downstream of the dense_4 layer (32 inputs → 5 logits, 22-bit signed, 11 fractional bits). Accepts one 5-logit vector per handshake, scans it serially with a single signed comparator, and returns the winning jet class index, the winning logit, and the margin to the runner-up as a confidence measure. Replaces a softmax in the hardware path, since the class decision needs only the ordering.

## Interface
- WIDTH, 22, logit width (signed two's complement)
- NFRAC, 11, fractional bits (informational; the arithmetic is format-agnostic)
- N_CLASSES, 5, logits per vector (must be ≥2)
- IDX_W, 3, class index width, ≥ clog2(N_CLASSES)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  N_CLASSES*WIDTH  logits; class k occupies bits [k*WIDTH +: WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_class  out  IDX_W  index of maximum logit
- out_max  out  WIDTH  maximum logit, signed
- out_margin  out  WIDTH  max minus second-max, non-negative, saturated

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - capture in_data into an internal vector register;
  - best=logit0, idx=0, second=−2^(WIDTH−1), cnt=1;
  - go to SCAN.
- SCAN: one compare per cycle on x=logit[cnt], signed:
  - x>best (strict): second=best, best=x, idx=cnt;
  - else x>second: second=x.
  - cnt++. After the compare with cnt==N_CLASSES−1, go to DONE.
- Tie rules:
  - ties never displace best, so the lowest index wins;
  - a value equal to best becomes second, giving margin 0.
- DONE: out_valid=1; out_class/out_max/out_margin stable. On out_ready, go to IDLE.
- Margin: best−second computed in WIDTH+1 bits. Result is clamped to 2^(WIDTH−1)−1 when larger; it is never negative.
- in_ready=0 in SCAN and DONE. The input vector is not sampled outside the IDLE handshake, so upstream may change in_data freely.
- Outputs are registered. out_class/out_max/out_margin are loaded on entry to DONE and hold their values until the next DONE entry.

## Timing
- Reset (asynchronous assert, synchronous release by clk):
  - state=IDLE, out_valid=0, out_class=0, out_max=0, out_margin=0;
  - internal registers are cleared;
  - in_ready=0 while reset is high.
- Latency: accept edge E0; compares on edges E1..E(N_CLASSES−1). out_valid goes high after edge E(N_CLASSES−1), i.e. 4 cycles after accept for N_CLASSES=5.
- Throughput: N_CLASSES+1 = 6 cycles per vector with out_ready held high (accept, 4 scan, DONE handoff).
- Backpressure: DONE holds indefinitely. All outputs are constant while out_valid&&!out_ready.
- Reset mid-SCAN or mid-DONE aborts the vector: no out_valid pulse, and nothing is carried into the next vector.
- No combinational path from in_valid/out_ready to any output except in_ready, which is a function of state and reset only.

## Test plan
- Nominal: logits raw {−128, −129, −144, 168, 441} (≈ −0.062, −0.063, −0.070, 0.082, 0.215) → out_class=4, out_max=441, out_margin=273; out_valid rises 4 cycles after accept.
- Ties: all logits = 100 → out_class=0, out_max=100, out_margin=0. Logits {5, 9, 9, 1, 0} → class 1, margin 0.
- Saturation/extremes:
  - class 2 = 2097151, others = −2097152 → class 2, out_max=2097151, out_margin=2097151 (clamped).
  - All logits = −2097152 → class 0, margin 0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0 throughout.
  - Raise out_ready → IDLE next cycle, next vector accepted one cycle later.
- Reset mid-operation: assert reset 2 cycles into SCAN → out_valid stays 0 and all outputs are 0. After release, vector {0, 0, 0, 0, 3} → class 4, margin 3.
- Back-to-back: in_valid and out_ready held high with 3 distinct vectors → results in order, accept edges exactly 6 cycles apart.
